// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG scan master: controller states, TAP
// walk constants and the IR opcodes understood by the OnboardTop TAP.
package jtag_pkg;

    // Mirror of the target TAP state as seen by the master.
    typedef enum logic [3:0] {
        S_TLR,
        S_IDLE,
        S_SEL_DR,
        S_SEL_IR,
        S_CAPTURE,
        S_SHIFT,
        S_EXIT1,
        S_UPDATE,
        S_DONE
    } state_e;

    // TCK periods with TMS=1 that force any TAP into Test-Logic-Reset.
    localparam int TLR_CYCLES = 5;

    // TMS values from Run-Test/Idle to Shift, bit 0 presented first.
    localparam logic [2:0] TMS_PRE_DR = 3'b001;
    localparam logic [3:0] TMS_PRE_IR = 4'b0011;

    // OnboardTop instruction opcodes.
    localparam logic [3:0] IR_SAMPLE = 4'b0001;
    localparam logic [3:0] IR_INTEST = 4'b0011;
    localparam logic [3:0] IR_BYPASS = 4'b1111;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider. Each TCK half-period lasts TCK_DIV clocks. fall_stb marks the
// end of a high phase (TMS/TDI update point), rise_stb the end of a low phase
// (TDO sample point). When run drops, the current high phase is completed and
// TCK then parks low. Starting from park emits an immediate fall_stb so the
// first TMS value is set up a full low phase before the first rising edge.
module jtag_tck_gen #(
    parameter int TCK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic tck_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TCK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d;
    logic          act_q, act_d;
    logic          phase_end;

    // Phase counter, TCK toggle and park/unpark control.
    always_comb begin
        cnt_d      = cnt_q;
        tck_d      = tck_q;
        act_d      = act_q;
        phase_end  = act_q && (cnt_q == CNT_MAX);
        rise_stb_o = phase_end && !tck_q;
        fall_stb_o = (phase_end && tck_q) || (!act_q && run_i);
        if (!act_q) begin
            cnt_d = '0;
            tck_d = 1'b0;
            act_d = run_i;
        end else if (phase_end) begin
            cnt_d = '0;
            tck_d = !tck_q;
            if (tck_q && !run_i) begin
                act_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
            act_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
            act_q <= act_d;
        end
    end

    assign tck_o = tck_q;

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan initiator. Accepts one IR or DR scan command, walks the target
// TAP from Run-Test/Idle to Shift, shifts len bits (bit 0 first), passes
// Exit1/Update back to Idle and presents the captured TDO bits. TMS/TDI are
// updated on the TCK falling strobe; the TAP mirror advances and TDO is
// sampled on the rising strobe.
// Handshake: start is a one-cycle strobe honoured only while busy is low;
// done pulses for one cycle when tdo_data is valid; err pulses one cycle
// after a start carrying an out-of-range len, which is otherwise dropped.
module jtag_scan_master
    import jtag_pkg::*;
#(
    parameter  int MAX_LEN = 32,
    parameter  int TCK_DIV = 4,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESETN,
    input  logic               start,
    input  logic               is_ir,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] tdi_data,
    output logic [MAX_LEN-1:0] tdo_data,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    input  logic               jtag_tdo
);

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic [2:0]         tlr_q, tlr_d;
    logic               is_ir_q, is_ir_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [MAX_LEN-1:0] sh_in_q, sh_in_d;
    logic [MAX_LEN-1:0] tdo_q, tdo_d;
    logic [LEN_W-1:0]   bit_idx;
    logic               len_ok;
    logic               rise_stb;
    logic               fall_stb;

    jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk_i      (CLK100MHZ),
        .rst_ni     (CPU_RESETN),
        .run_i      (busy_q),
        .tck_o      (jtag_tck),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    // Command accept, TMS/TDI drive on falling strobes, TAP walk and TDO capture on rising strobes.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        tlr_d   = tlr_q;
        is_ir_d = is_ir_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sh_in_d = sh_in_q;
        tdo_d   = tdo_q;
        bit_idx = len_q - cnt_q - LEN_W'(1);
        len_ok  = (len != '0) && (len <= LEN_W'(MAX_LEN));

        if (!busy_q && (state_q == S_IDLE || state_q == S_DONE)) begin
            state_d = S_IDLE;
            if (start) begin
                if (len_ok) begin
                    busy_d  = 1'b1;
                    is_ir_d = is_ir;
                    len_d   = len;
                    cnt_d   = len - LEN_W'(1);
                    sh_in_d = tdi_data;
                    tdo_d   = '0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        if (fall_stb && busy_q) begin
            tdi_d = 1'b0;
            case (state_q)
                S_TLR:     tms_d = (tlr_q < 3'(TLR_CYCLES));
                S_IDLE:    tms_d = TMS_PRE_DR[0];
                S_SEL_DR:  tms_d = is_ir_q ? TMS_PRE_IR[1] : TMS_PRE_DR[1];
                S_SEL_IR:  tms_d = TMS_PRE_IR[2];
                S_CAPTURE: tms_d = is_ir_q ? TMS_PRE_IR[3] : TMS_PRE_DR[2];
                S_SHIFT: begin
                    tms_d   = (cnt_q == '0);
                    tdi_d   = sh_in_q[0];
                    sh_in_d = sh_in_q >> 1;
                end
                S_EXIT1:   tms_d = 1'b1;
                S_UPDATE:  tms_d = 1'b0;
                default:   tms_d = tms_q;
            endcase
        end

        if (rise_stb && busy_q) begin
            case (state_q)
                S_TLR: begin
                    if (tlr_q == 3'(TLR_CYCLES)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        tlr_d = tlr_q + 3'd1;
                    end
                end
                S_IDLE:    state_d = S_SEL_DR;
                S_SEL_DR:  state_d = is_ir_q ? S_SEL_IR : S_CAPTURE;
                S_SEL_IR:  state_d = S_CAPTURE;
                S_CAPTURE: state_d = S_SHIFT;
                S_SHIFT: begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (LEN_W'(i) == bit_idx) begin
                            tdo_d[i] = jtag_tdo;
                        end
                    end
                    if (cnt_q == '0) begin
                        state_d = S_EXIT1;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
                S_EXIT1:   state_d = S_UPDATE;
                S_UPDATE: begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                end
                default:   state_d = state_q;
            endcase
        end
    end

    // Controller registers; reset forces the TLR walk with TMS held high.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= S_TLR;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            tlr_q   <= '0;
            is_ir_q <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            sh_in_q <= '0;
            tdo_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            tlr_q   <= tlr_d;
            is_ir_q <= is_ir_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sh_in_q <= sh_in_d;
            tdo_q   <= tdo_d;
        end
    end

    assign tdo_data = tdo_q;
    assign busy     = busy_q;
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign jtag_tms = tms_q;
    assign jtag_tdi = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master. A behavioural target on the JTAG pins logs TMS
// and TDI at each TCK rise and drives TDO on each TCK fall, either from a
// random pattern or as a one-bit delay of TDI (bypass-like). Expected TMS
// streams, TDI bits and tdo_data are built from the scan rules alone.
module tb_jtag_scan_master;
  import jtag_pkg::*;

  localparam int MAX_LEN = 32;
  localparam int TCK_DIV = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               start    = 1'b0;
  logic               is_ir    = 1'b0;
  logic [LEN_W-1:0]   len      = '0;
  logic [MAX_LEN-1:0] tdi_data = '0;
  logic [MAX_LEN-1:0] tdo_data;
  logic               busy, done, err;
  logic               jtag_tck, jtag_tms, jtag_tdi;
  logic               jtag_tdo = 1'b0;

  jtag_scan_master #(
    .MAX_LEN (MAX_LEN),
    .TCK_DIV (TCK_DIV)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .start      (start),
    .is_ir      (is_ir),
    .len        (len),
    .tdi_data   (tdi_data),
    .tdo_data   (tdo_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .jtag_tck   (jtag_tck),
    .jtag_tms   (jtag_tms),
    .jtag_tdi   (jtag_tdi),
    .jtag_tdo   (jtag_tdo)
  );

  // target model
  logic [127:0] pat = '0;
  int           rise_cnt = 0;
  bit           echo_mode = 1'b0;
  logic         last_tdi = 1'b0;
  logic         tms_log[$];
  logic         tdi_log[$];

  always @(posedge jtag_tck) begin
    tms_log.push_back(jtag_tms);
    tdi_log.push_back(jtag_tdi);
    last_tdi = jtag_tdi;
    rise_cnt++;
  end

  always @(negedge jtag_tck) begin
    jtag_tdo = echo_mode ? last_tdi : pat[7'(rise_cnt)];
  end

  int done_cnt = 0;
  int err_cnt  = 0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  // scoreboard
  int         n_vec = 0;
  int         n_err = 0;
  logic [0:0] exp_q[$];

  task automatic check_val(input string tag, input logic [MAX_LEN-1:0] got,
                           input logic [MAX_LEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    tms_log.delete();
    tdi_log.delete();
    rise_cnt = 0;
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // compare logged TMS stream against exp_q
  task automatic check_tms(input string tag);
    int n = exp_q.size();
    check_val({tag, "_tck_count"}, tms_log.size(), n);
    for (int i = 0; i < n; i++) begin
      logic [0:0] e = exp_q.pop_front();
      if (i < tms_log.size()) check_val($sformatf("%s_tms[%0d]", tag, i), tms_log[i], e);
    end
    exp_q.delete();
  endtask

  // wait for the post-reset walk and check it
  task automatic check_tlr(input string tag);
    int t = 0;
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_val({tag, "_busy_drop"}, busy, 1'b0);
    for (int i = 0; i < 6; i++) exp_q.push_back(i < 5 ? 1'b1 : 1'b0);
    check_tms(tag);
    check_val({tag, "_no_done"}, done_cnt, 0);
  endtask

  // driver: one full scan with its expectations
  task automatic run_scan(input bit ir, input int n, input logic [MAX_LEN-1:0] din,
                          input bit echo, input bit poke, input bit wait_idle);
    int                 pre = 3 + int'(ir);
    int                 t = 0;
    logic [MAX_LEN-1:0] exp_tdo = '0;
    @(negedge clk);
    clear_logs();
    echo_mode = echo;
    pat = {$urandom(), $urandom(), $urandom(), $urandom()};
    jtag_tdo = echo ? last_tdi : pat[0];
    for (int k = 0; k < n; k++) begin
      if (echo) exp_tdo[k] = (k == 0) ? 1'b0 : din[k-1];
      else      exp_tdo[k] = pat[7'(pre + k)];
    end
    exp_q.push_back(1'b1);
    if (ir) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    for (int k = 0; k < n - 1; k++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    start    = 1'b1;
    is_ir    = ir;
    len      = LEN_W'(n);
    tdi_data = din;
    @(negedge clk);
    start    = 1'b0;
    is_ir    = 1'($urandom());
    len      = LEN_W'($urandom());
    tdi_data = $urandom();
    check_val("busy_after_start", busy, 1'b1);
    if (poke) begin
      repeat ($urandom_range(2, 40)) @(negedge clk);
      start = 1'b1;
      len   = '0;
      @(negedge clk);
      start = 1'b0;
    end
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_val("done_seen", done, 1'b1);
    check_val("busy_at_done", busy, 1'b0);
    check_val($sformatf("tdo_data_len%0d", n), tdo_data, exp_tdo);
    for (int k = 0; k < n; k++) begin
      if (pre + k < tdi_log.size())
        check_val($sformatf("tdi_bit[%0d]", k), tdi_log[pre + k], din[k]);
    end
    check_tms(ir ? "ir" : "dr");
    check_val("no_err", err_cnt, 0);
    if (wait_idle) begin
      repeat (4 * TCK_DIV) @(negedge clk);
      check_val("idle_tck", jtag_tck, 1'b0);
      check_val("idle_tms", jtag_tms, 1'b0);
      check_val("idle_busy", busy, 1'b0);
      check_val("done_once", done_cnt, 1);
    end
  endtask

  // driver: a start with an illegal length
  task automatic try_bad_len(input int n);
    int r0;
    @(negedge clk);
    r0 = rise_cnt;
    err_cnt  = 0;
    start    = 1'b1;
    is_ir    = 1'($urandom());
    len      = LEN_W'(n);
    tdi_data = $urandom();
    @(negedge clk);
    start = 1'b0;
    check_val($sformatf("err_pulse_len%0d", n), err, 1'b1);
    check_val("err_busy", busy, 1'b0);
    @(negedge clk);
    check_val("err_single", err, 1'b0);
    repeat (40) @(negedge clk);
    check_val("err_no_tck", rise_cnt - r0, 0);
    check_val("err_busy_later", busy, 1'b0);
    check_val("err_count", err_cnt, 1);
  endtask

  // driver: reset asserted in the middle of a DR shift
  task automatic reset_mid_scan();
    int t = 0;
    @(negedge clk);
    start    = 1'b1;
    is_ir    = 1'b0;
    len      = LEN_W'(24);
    tdi_data = $urandom();
    @(negedge clk);
    start = 1'b0;
    rise_cnt = 0;
    while (rise_cnt < 12 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_val("mid_shift_reached", rise_cnt >= 12, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("mrst_tck", jtag_tck, 1'b0);
    check_val("mrst_tms", jtag_tms, 1'b1);
    check_val("mrst_tdi", jtag_tdi, 1'b0);
    check_val("mrst_busy", busy, 1'b1);
    check_val("mrst_done", done, 1'b0);
    check_val("mrst_tdo_data", tdo_data, '0);
    repeat (5) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    check_tlr("mrst_tlr");
    run_scan(1'($urandom()), $urandom_range(1, MAX_LEN), $urandom(), 1'($urandom()), 1'b0, 1'b1);
  endtask

  // main sequence and final report
  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_tck", jtag_tck, 1'b0);
    check_val("rst_tms", jtag_tms, 1'b1);
    check_val("rst_tdi", jtag_tdi, 1'b0);
    check_val("rst_tdo_data", tdo_data, '0);
    check_val("rst_busy", busy, 1'b1);
    check_val("rst_done", done, 1'b0);
    check_val("rst_err", err, 1'b0);
    clear_logs();
    rst_n = 1'b1;
    check_tlr("boot_tlr");

    run_scan(1'b1, 4, {28'd0, IR_SAMPLE}, 1'b0, 1'b0, 1'b1);
    run_scan(1'b1, 4, {28'd0, IR_BYPASS}, 1'b0, 1'b0, 1'b1);
    run_scan(1'b0, 8, 32'h0000_00A5, 1'b1, 1'b0, 1'b1);
    check_val("bypass_a5", tdo_data, 32'h0000_004A);
    run_scan(1'b0, 1, 32'h1, 1'b0, 1'b0, 1'b1);
    run_scan(1'b1, MAX_LEN, $urandom(), 1'b0, 1'b1, 1'b1);

    try_bad_len(0);
    try_bad_len(MAX_LEN + 1);

    for (int i = 0; i < 24; i++) begin
      run_scan(1'($urandom()), $urandom_range(1, MAX_LEN), $urandom(),
               1'($urandom()), 1'($urandom()), (i % 3) != 0);
    end

    reset_mid_scan();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
